iis_pll_ctrl: RTL and testbench
===============================

# iis_pll_ctrl

Sequencing controller for the I2S audio rPLL. It programs the PLL's dynamic input, feedback and output divider selects from a small rate table, and pulses the PLL reset. It then waits for a stable lock, with timeout and bounded retry, before releasing the I2S clock domain through `clk_ok`. The block runs on the free-running crystal clock that also feeds the PLL input, and sits between the USB control logic (rate requests) and the rPLL / I2S serializer.

## Interface
- `GATE_CYC`, 16: cycles `clk_ok` is held low before the PLL is touched (downstream quiesce).
- `RST_CYC`, 32: cycles `pll_reset` is held high per attempt.
- `LOCK_STABLE`, 64: consecutive synced-lock cycles required before RUN.
- `LOCK_TIMEOUT`, 4096: cycle budget per attempt, counted from entry to WAIT_LOCK.
- `MAX_RETRY`, 2: extra attempts after the first before ERROR.
- `DEFAULT_RATE`, 0: rate index programmed after reset.
- `clk` in 1: crystal clock, same source as PLL CLKIN.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: rate-change request.
- `req_rate` in 2: requested rate index (0..3, all valid).
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `pll_lock` in 1: rPLL LOCK (asynchronous; synchronized internally).
- `pll_reset` out 1: rPLL RESET.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel` out 6 each: rPLL IDSEL/FBDSEL/ODSEL, encoded per package table.
- `clk_ok` out 1: PLL output valid; I2S logic runs only while high.
- `busy` out 1: sequence in progress.
- `err` out 1: lock failed after all retries.
- `cur_rate` out 2: index currently programmed.
- `lock_loss_cnt` out 8: saturating lock-loss counter (see Configuration).

## Operation
- States: GATE, PRESET, WAIT_LOCK, SETTLE, RUN, ERROR.
- Reset values:
  - state = PRESET.
  - `pll_reset`=1, `clk_ok`=0, `busy`=1, `err`=0, `req_ready`=0.
  - Selects = table[`DEFAULT_RATE`], `cur_rate`=`DEFAULT_RATE`.
  - Counters and `lock_loss_cnt` = 0.
- The boot sequence starts in PRESET and skips GATE.
- `req_ready`=1 only in RUN and ERROR.
- Accepting a request:
  - In RUN with `req_rate`==`cur_rate`: acknowledged, no action.
  - Any other accepted request latches the index, clears the retry count and `err`, and goes to GATE.
- GATE: `clk_ok`=0 and `busy`=1 for `GATE_CYC` cycles, then PRESET.
- PRESET:
  - On entry, the selects and `cur_rate` load the latched index.
  - `pll_reset`=1 for `RST_CYC` cycles, then WAIT_LOCK.
- WAIT_LOCK: `pll_reset`=0. Moves to SETTLE when synced lock is 1.
- SETTLE:
  - Synced lock 1 for `LOCK_STABLE` consecutive cycles: RUN.
  - Lock dropping: back to WAIT_LOCK, stable count cleared, timeout count kept.
- Timeout: the timeout count runs through WAIT_LOCK and SETTLE.
  - Reaching `LOCK_TIMEOUT` with retries < `MAX_RETRY`: retry++ and go to PRESET.
  - Otherwise: ERROR.
- RUN: `clk_ok`=1, `busy`=0.
- ERROR: `err`=1, `pll_reset`=1, `clk_ok`=0, `busy`=0. Exits only on an accepted request.
- Asserting `rst_n` low mid-sequence returns immediately to reset values; the boot sequence restarts with `DEFAULT_RATE`.

## Timing
- `pll_lock` passes through a 2-flop synchronizer, adding 2 cycles of latency.
- Request accepted at cycle N:
  - `clk_ok`=0 at N+1.
  - Selects change and `pll_reset` rises at N+1+`GATE_CYC`.
  - `pll_reset` falls at N+1+`GATE_CYC`+`RST_CYC`.
- Synced lock first high at cycle M with no drop: `clk_ok`=1 at M+`LOCK_STABLE`.
- Selects are stable whenever `pll_reset`=0. They change only on PRESET entry.
- All outputs are registered.

## Configuration
- `IIS_PLL_LOCKMON_EN` defined:
  - In RUN, synced lock low for 2 consecutive cycles drops `clk_ok` the next cycle and increments `lock_loss_cnt` (saturating at 255).
  - The block then enters PRESET with the same index and a cleared retry count.
- Undefined: lock is ignored in RUN and `lock_loss_cnt` is tied to 0.

## Structure
- Package `iis_pll_pkg` holds:
  - The state enum.
  - The 4-entry rate table (IDSEL/FBDSEL/ODSEL constants).
  - The rate-index width.
- Sub-module `iis_sync2` is the 2-flop synchronizer for `pll_lock`, with async active-low reset to 0.

## Test plan
- Boot with lock tied to go high 100 cycles after `pll_reset` falls:
  - `pll_reset` high 32 cycles, selects = table[0].
  - `clk_ok`=1 exactly 2+64 cycles after lock rises; `busy`=0.
- In RUN, request rate 2:
  - `clk_ok` low at N+1, selects = table[2] at N+17, `pll_reset` pulse of 32 cycles.
  - `cur_rate`=2, then relock.
- Lock never rises:
  - 3 PRESET pulses (1 + `MAX_RETRY`), each 4096 cycles apart.
  - Then ERROR: `err`=1, `pll_reset`=1. A new request clears `err`.
- Lock glitches low for 1 cycle at SETTLE cycle 40:
  - Returns to WAIT_LOCK; RUN only after 64 further stable cycles.
- With `IIS_PLL_LOCKMON_EN`, lock dropped for 3 cycles in RUN:
  - `clk_ok` falls, `lock_loss_cnt`=1, relock on the same rate.
  - Without the macro there is no reaction.
- `rst_n` asserted during WAIT_LOCK:
  - All outputs return to reset values immediately.
  - Boot restarts with rate 0.

Source files
------------

// File: rtl/iis_pll_pkg.sv
// iis_pll_pkg: shared types, sizes and rate table for the I2S rPLL sequencer.
package iis_pll_pkg;

  localparam int unsigned RATE_W = 2;
  localparam int unsigned SEL_W  = 6;

  typedef logic [RATE_W-1:0] rate_t;

  typedef enum logic [2:0] {
    ST_GATE,
    ST_PRESET,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] idsel;
    logic [SEL_W-1:0] fbdsel;
    logic [SEL_W-1:0] odsel;
  } pll_sel_t;

  // Rate table; each field is in rPLL select encoding (64 minus the divide value).
  function automatic pll_sel_t rate_sel(input rate_t r);
    pll_sel_t s;
    case (r)
      2'd0:    s = '{idsel: 6'd63, fbdsel: 6'd55, odsel: 6'd56};
      2'd1:    s = '{idsel: 6'd62, fbdsel: 6'd47, odsel: 6'd60};
      2'd2:    s = '{idsel: 6'd61, fbdsel: 6'd41, odsel: 6'd48};
      default: s = '{idsel: 6'd59, fbdsel: 6'd33, odsel: 6'd52};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/iis_sync2.sv
// iis_sync2: two-flop synchronizer, resets to 0.
module iis_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/iis_pll_ctrl.sv
// iis_pll_ctrl: programs the rPLL divider selects for the requested audio rate,
// pulses the PLL reset, waits for stable lock with timeout/retry, then opens
// clk_ok for the I2S domain. Define IIS_PLL_LOCKMON_EN to relock on lock loss
// while running and count those events in o_lock_loss_cnt.
module iis_pll_ctrl
  import iis_pll_pkg::*;
#(
  parameter int unsigned GATE_CYC     = 16,
  parameter int unsigned RST_CYC      = 32,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned DEFAULT_RATE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [RATE_W-1:0] i_req_rate,
  output logic              o_req_ready,
  input  logic              i_pll_lock,
  output logic              o_pll_reset,
  output logic [SEL_W-1:0]  o_pll_idsel,
  output logic [SEL_W-1:0]  o_pll_fbdsel,
  output logic [SEL_W-1:0]  o_pll_odsel,
  output logic              o_clk_ok,
  output logic              o_busy,
  output logic              o_err,
  output logic [RATE_W-1:0] o_cur_rate,
  output logic [7:0]        o_lock_loss_cnt
);

  localparam int unsigned CNT_MAX = (GATE_CYC > RST_CYC) ? GATE_CYC : RST_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam rate_t       DEF_RATE = rate_t'(DEFAULT_RATE);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic [STB_W-1:0] r_stab, w_stab;
  logic [RTY_W-1:0] r_retry, w_retry;
  rate_t            r_rate, w_rate;
  rate_t            r_cur_rate, w_cur_rate;
  pll_sel_t         r_sel, w_sel;
  logic             r_pll_reset, w_pll_reset;
  logic             r_clk_ok, w_clk_ok;
  logic             r_busy, w_busy;
  logic             r_err, w_err;
  logic             r_req_ready, w_req_ready;
  logic             w_lock;
  logic             w_acc;
  logic             w_tmo_hit;
  logic             w_load;
`ifdef IIS_PLL_LOCKMON_EN
  logic             r_lowseen, w_lowseen;
  logic [7:0]       r_loss, w_loss;
`endif

  iis_sync2 u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_lock),
    .o_q     (w_lock)
  );

  assign w_acc     = i_req_valid && r_req_ready;
  assign w_tmo_hit = (r_tmo == TMO_W'(LOCK_TIMEOUT - 1));

  // Next-state, counter and registered-output computation.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_tmo   = r_tmo;
    w_stab  = r_stab;
    w_retry = r_retry;
    w_rate  = r_rate;
`ifdef IIS_PLL_LOCKMON_EN
    w_lowseen = 1'b0;
    w_loss    = r_loss;
`endif
    case (r_state)
      ST_GATE: begin
        if (r_cnt == CNT_W'(GATE_CYC - 1)) begin
          w_state = ST_PRESET;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESET: begin
        if (r_cnt == CNT_W'(RST_CYC - 1)) begin
          w_state = ST_WAIT_LOCK;
          w_cnt   = '0;
          w_tmo   = '0;
          w_stab  = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK, ST_SETTLE: begin
        if (r_state == ST_WAIT_LOCK) begin
          if (w_lock) begin
            w_state = ST_SETTLE;
            w_stab  = STB_W'(1);
          end
        end else if (!w_lock) begin
          w_state = ST_WAIT_LOCK;
          w_stab  = '0;
        end else if (r_stab == STB_W'(LOCK_STABLE - 1)) begin
          w_state = ST_RUN;
        end else begin
          w_stab = r_stab + STB_W'(1);
        end
        // Lock completing on the final budget cycle takes precedence over timeout.
        if (w_state != ST_RUN) begin
          if (w_tmo_hit) begin
            if (r_retry < RTY_W'(MAX_RETRY)) begin
              w_state = ST_PRESET;
              w_cnt   = '0;
              w_retry = r_retry + RTY_W'(1);
            end else begin
              w_state = ST_ERROR;
            end
          end else begin
            w_tmo = r_tmo + TMO_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (w_acc && (i_req_rate != r_cur_rate)) begin
          w_state = ST_GATE;
          w_cnt   = '0;
          w_rate  = i_req_rate;
          w_retry = '0;
        end
`ifdef IIS_PLL_LOCKMON_EN
        else if (!w_lock) begin
          if (r_lowseen) begin
            w_state = ST_PRESET;
            w_cnt   = '0;
            w_retry = '0;
            if (r_loss != 8'hFF) w_loss = r_loss + 8'd1;
          end else begin
            w_lowseen = 1'b1;
          end
        end
`endif
      end
      ST_ERROR: begin
        if (w_acc) begin
          w_state = ST_GATE;
          w_cnt   = '0;
          w_rate  = i_req_rate;
          w_retry = '0;
        end
      end
      default: w_state = ST_PRESET;
    endcase

    w_load      = (w_state == ST_PRESET) && (r_state != ST_PRESET);
    w_sel       = w_load ? rate_sel(r_rate) : r_sel;
    w_cur_rate  = w_load ? r_rate : r_cur_rate;
    w_clk_ok    = (w_state == ST_RUN);
    w_busy      = (w_state != ST_RUN) && (w_state != ST_ERROR);
    w_req_ready = (w_state == ST_RUN) || (w_state == ST_ERROR);
    w_err       = (w_state == ST_ERROR);
    case (w_state)
      ST_GATE:             w_pll_reset = r_pll_reset;
      ST_PRESET, ST_ERROR: w_pll_reset = 1'b1;
      default:             w_pll_reset = 1'b0;
    endcase
  end

  // State, counters and outputs register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_PRESET;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_stab      <= '0;
      r_retry     <= '0;
      r_rate      <= DEF_RATE;
      r_cur_rate  <= DEF_RATE;
      r_sel       <= rate_sel(DEF_RATE);
      r_pll_reset <= 1'b1;
      r_clk_ok    <= 1'b0;
      r_busy      <= 1'b1;
      r_err       <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_stab      <= w_stab;
      r_retry     <= w_retry;
      r_rate      <= w_rate;
      r_cur_rate  <= w_cur_rate;
      r_sel       <= w_sel;
      r_pll_reset <= w_pll_reset;
      r_clk_ok    <= w_clk_ok;
      r_busy      <= w_busy;
      r_err       <= w_err;
      r_req_ready <= w_req_ready;
    end
  end

`ifdef IIS_PLL_LOCKMON_EN
  // Lock-loss detector history and saturating event counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lowseen <= 1'b0;
      r_loss    <= '0;
    end else begin
      r_lowseen <= w_lowseen;
      r_loss    <= w_loss;
    end
  end
  assign o_lock_loss_cnt = r_loss;
`else
  assign o_lock_loss_cnt = '0;
`endif

  assign o_req_ready  = r_req_ready;
  assign o_pll_reset  = r_pll_reset;
  assign o_pll_idsel  = r_sel.idsel;
  assign o_pll_fbdsel = r_sel.fbdsel;
  assign o_pll_odsel  = r_sel.odsel;
  assign o_clk_ok     = r_clk_ok;
  assign o_busy       = r_busy;
  assign o_err        = r_err;
  assign o_cur_rate   = r_cur_rate;

endmodule

// File: tb/tb_iis_pll_ctrl.sv
// tb_iis_pll_ctrl: randomized sequencing scenarios checked against cycle-count
// arithmetic derived from the sequencer's timing rules.
module tb_iis_pll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_rate = 2'd0;
  logic       pll_lock = 1'b0;
  logic       req_ready, pll_reset, clk_ok, busy, err;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] cur_rate;
  logic [7:0] loss_cnt;

  iis_pll_ctrl #(
    .GATE_CYC     (16),
    .RST_CYC      (32),
    .LOCK_STABLE  (64),
    .LOCK_TIMEOUT (4096),
    .MAX_RETRY    (2),
    .DEFAULT_RATE (0)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .i_req_rate      (req_rate),
    .o_req_ready     (req_ready),
    .i_pll_lock      (pll_lock),
    .o_pll_reset     (pll_reset),
    .o_pll_idsel     (idsel),
    .o_pll_fbdsel    (fbdsel),
    .o_pll_odsel     (odsel),
    .o_clk_ok        (clk_ok),
    .o_busy          (busy),
    .o_err           (err),
    .o_cur_rate      (cur_rate),
    .o_lock_loss_cnt (loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int m_rate = 0;
  int m_loss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_sel(input int r);
    case (r)
      0:       return {6'd63, 6'd55, 6'd56};
      1:       return {6'd62, 6'd47, 6'd60};
      2:       return {6'd61, 6'd41, 6'd48};
      default: return {6'd59, 6'd33, 6'd52};
    endcase
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return clk_ok;
      default: return err;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string tag, input int sel, input logic val, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sig(sel) == val) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk({tag, "_timeout"}, 32'(sig(sel)), 32'(val));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
    chk({tag, "_clk_ok"}, 32'(clk_ok), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_cur_rate"}, 32'(cur_rate), 0);
    chk({tag, "_sel"}, 32'({idsel, fbdsel, odsel}), 32'(exp_sel(0)));
    chk({tag, "_loss"}, 32'(loss_cnt), 0);
  endtask

  // Lock raised d cycles after the caller's current cycle; RUN expected 2+64 later.
  task automatic relock(input string tag, input int d);
    int l, t;
    repeat (d) tick();
    pll_lock = 1'b1;
    l = cyc;
    wait_sig({tag, "_clkok"}, 1, 1'b1, 300, t);
    chk({tag, "_lock_to_clkok"}, t - l, 66);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    chk({tag, "_cur_rate"}, 32'(cur_rate), m_rate);
    chk({tag, "_sel"}, 32'({idsel, fbdsel, odsel}), 32'(exp_sel(m_rate)));
    chk({tag, "_loss"}, 32'(loss_cnt), m_loss);
  endtask

  task automatic change_rate(input string tag, input int r, input bit from_err, output int f);
    int n, t;
    req_valid = 1'b1;
    req_rate  = 2'(r);
    n = cyc;
    tick();
    req_valid = 1'b0;
    m_rate = r;
    chk({tag, "_clkok_n1"}, 32'(clk_ok), 0);
    chk({tag, "_busy_n1"}, 32'(busy), 1);
    chk({tag, "_err_n1"}, 32'(err), 0);
    chk({tag, "_ready_n1"}, 32'(req_ready), 0);
    if (!from_err) begin
      wait_sig({tag, "_rise"}, 0, 1'b1, 100, t);
      chk({tag, "_rise_at"}, t - n, 17);
      chk({tag, "_sel"}, 32'({idsel, fbdsel, odsel}), 32'(exp_sel(r)));
      chk({tag, "_cur"}, 32'(cur_rate), r);
      pll_lock = 1'b0;
    end
    wait_sig({tag, "_fall"}, 0, 1'b0, 100, f);
    chk({tag, "_fall_at"}, f - n, 49);
    if (from_err) chk({tag, "_sel_e"}, 32'({idsel, fbdsel, odsel}), 32'(exp_sel(r)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int f, t, r, d, l, g, r0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset("por");
    repeat (3) tick();
    rst_n = 1'b1;
    r0 = cyc;
    wait_sig("boot", 0, 1'b0, 100, f);
    chk("boot_rst_len", f - r0, 32);
    chk("boot_sel", 32'({idsel, fbdsel, odsel}), 32'(exp_sel(0)));
    chk("boot_clkok_low", 32'(clk_ok), 0);
    relock("boot", 100);

    change_rate("rate2", 2, 1'b0, f);
    relock("rate2", int'($urandom_range(20, 150)));

    for (int k = 0; k < 5; k++) begin
      r = int'($urandom_range(0, 3));
      if (r == m_rate) begin
        req_valid = 1'b1;
        req_rate  = 2'(r);
        tick();
        req_valid = 1'b0;
        chk("same_clkok", 32'(clk_ok), 1);
        chk("same_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("same_pll_reset", 32'(pll_reset), 0);
        chk("same_cur", 32'(cur_rate), m_rate);
      end else begin
        change_rate("rand", r, 1'b0, f);
        relock("rand", int'($urandom_range(5, 200)));
      end
    end

    // Single-cycle lock glitch during SETTLE restarts the stability window.
    r = (m_rate + int'($urandom_range(1, 3))) % 4;
    change_rate("glitch", r, 1'b0, f);
    repeat (int'($urandom_range(10, 100))) tick();
    pll_lock = 1'b1;
    l = cyc;
    g = (n_chk % 2 == 0) ? 40 : int'($urandom_range(20, 60));
    repeat (g) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    l = cyc;
    wait_sig("glitch_clkok", 1, 1'b1, 300, t);
    chk("glitch_relock_at", t - l, 66);
    chk("glitch_cur", 32'(cur_rate), m_rate);

    // Lock dropped for 3 cycles while running.
    repeat (5) tick();
    pll_lock = 1'b0;
    d = cyc;
    repeat (3) tick();
    pll_lock = 1'b1;
`ifdef IIS_PLL_LOCKMON_EN
    wait_sig("lmon_drop", 1, 1'b0, 20, t);
    chk("lmon_drop_at", t - d, 4);
    m_loss++;
    chk("lmon_loss", 32'(loss_cnt), m_loss);
    chk("lmon_pll_reset", 32'(pll_reset), 1);
    pll_lock = 1'b0;
    wait_sig("lmon_fall", 0, 1'b0, 100, f);
    chk("lmon_fall_at", f - t, 32);
    relock("lmon", int'($urandom_range(10, 100)));
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("nomon_clkok", 32'(clk_ok), 1);
    end
    chk("nomon_pll_reset", 32'(pll_reset), 0);
    chk("nomon_loss", 32'(loss_cnt), 0);
`endif

    // Lock never arrives: initial pulse plus two retries, then ERROR.
    r = (m_rate + int'($urandom_range(1, 3))) % 4;
    change_rate("tmo", r, 1'b0, f);
    for (int p = 0; p < 2; p++) begin
      wait_sig("tmo_retry", 0, 1'b1, 5000, t);
      chk("tmo_retry_gap", t - f, 4096);
      chk("tmo_retry_sel", 32'({idsel, fbdsel, odsel}), 32'(exp_sel(r)));
      wait_sig("tmo_retry_fall", 0, 1'b0, 100, f);
      chk("tmo_retry_len", f - t, 32);
    end
    wait_sig("tmo_err", 2, 1'b1, 5000, t);
    chk("tmo_err_gap", t - f, 4096);
    chk("tmo_err_pll_reset", 32'(pll_reset), 1);
    chk("tmo_err_clkok", 32'(clk_ok), 0);
    chk("tmo_err_busy", 32'(busy), 0);
    chk("tmo_err_ready", 32'(req_ready), 1);
    repeat (200) tick();
    chk("err_hold_pll_reset", 32'(pll_reset), 1);
    chk("err_hold_err", 32'(err), 1);
    change_rate("err_exit", int'($urandom_range(0, 3)), 1'b1, f);
    relock("err_exit", int'($urandom_range(10, 100)));

    // Reset asserted while waiting for lock.
    change_rate("midrst", int'($urandom_range(1, 3)), 1'b0, f);
    repeat (int'($urandom_range(1, 50))) tick();
    rst_n = 1'b0;
    #1;
    m_rate = 0;
    m_loss = 0;
    chk_reset("midrst");
    repeat (2) tick();
    chk("midrst_hold_reset", 32'(pll_reset), 1);
    rst_n = 1'b1;
    r0 = cyc;
    wait_sig("reboot", 0, 1'b0, 100, f);
    chk("reboot_rst_len", f - r0, 32);
    chk("reboot_sel", 32'({idsel, fbdsel, odsel}), 32'(exp_sel(0)));
    relock("reboot", int'($urandom_range(10, 100)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
